bcd_digit_display: RTL
======================

BCD_DIGIT_DISPLAY -- requirements
Module: bcd_digit_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, giving the clock cycles each display digit is lit (legal range 2..65535).
REQ-002 clk  input  1  The block SHALL use this single clock; every register updates on its rising edge.
REQ-003 rst_n  input  1  The block SHALL use this synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 digit_in  input  4  The BCD digit from the upstream decimal-to-BCD encoder.
REQ-005 digit_valid  input  1  Single-cycle strobe that qualifies digit_in.
REQ-006 clear  input  1  Synchronous clear of the entered value.
REQ-007 value  output  16  Four packed BCD digits; value[3:0] is the least significant digit.
REQ-008 count  output  3  Number of digits entered, 0..4.
REQ-009 overflow  output  1  Sticky flag: a digit was shifted out of the most significant position.
REQ-010 err  output  1  One-cycle pulse: a non-BCD digit was rejected.
REQ-011 seg  output  7  Active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-012 an  output  4  Active-low digit enables, one-hot; an[0] enables the least significant digit.

Function
REQ-013 When digit_valid=1 and digit_in<=9, the block SHALL update value to {value[11:0],digit_in} on the next edge.
REQ-014 On an accepted digit, count SHALL increment, saturating at 4.
REQ-015 An accepted digit arriving while count==4 SHALL set overflow to 1; overflow SHALL stay set until clear or reset.
REQ-016 When digit_valid=1 and digit_in>=10, the block SHALL leave value and count unchanged and SHALL assert err for exactly the next cycle.
REQ-017 err SHALL be 0 in every other cycle.
REQ-018 When clear=1, the block SHALL set value, count and overflow to 0 on the next edge.
REQ-019 clear SHALL take priority over a simultaneous digit_valid; that digit is dropped and err stays 0.
REQ-020 digit_valid SHALL be sampled as a level: if held high for N cycles, the block SHALL process N digits.
REQ-021 The scan counter SHALL run 0..SCAN_DIV-1 and wrap to 0.
REQ-022 When the scan counter wraps, the scan index SHALL advance 0->1->2->3->0.
REQ-023 an SHALL equal ~(4'b0001 << index).
REQ-024 seg SHALL show the 7-segment pattern for digit value[4*index+3:4*index].
REQ-025 Leading-zero blanking: when index>=count and index!=0, seg SHALL be 7'b1111111.
REQ-026 Digit 0 SHALL always be displayed, so it shows "0" when count==0.
REQ-027 seg and an SHALL be registered and SHALL reflect the index and value of the previous cycle (latency 1).
REQ-028 Entering or clearing digits SHALL NOT disturb the scan counter or the scan index.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL load value=0, count=0, overflow=0, err=0, scan counter=0, index=0, an=4'b1110 and seg=7'b1000000 (digit "0").
REQ-030 Reset SHALL take priority over clear and digit_valid.
REQ-031 Reset asserted mid-scan or mid-entry SHALL discard all state, with no partial update.

Structure
REQ-032 Shared package bcd_pkg SHALL hold the following, for reuse by the encoder and display stages:
- BCD digit width constant (4);
- 10-entry segment pattern constant table;
- SEG_BLANK constant (7'b1111111).
REQ-033 A combinational sub-module bcd_to_7seg (4-bit in, 7-bit active-low out, blank for codes 10-15) SHALL perform segment decode.
REQ-034 The scan divider, entry register and output registers SHALL live in the top module.

Verification
REQ-035 Reset, then strobe digits 1,2,3 on consecutive cycles -> value=16'h0123, count=3, overflow=0, err never 1.
REQ-036 Strobe 9,8,7,6,5 -> value=16'h8765, count=4, overflow=1; then clear -> value=0, count=0, overflow=0.
REQ-037 digit_valid with digit_in=4'hC while value=16'h0042 -> value unchanged, err=1 for exactly one cycle.
REQ-038 clear and digit_valid (digit 5) in the same cycle -> value=0, count=0, err=0.
REQ-039 SCAN_DIV=4, value=16'h0007, count=1, 16 cycles observed:
- an cycles 1110,1101,1011,0111, each held 4 cycles;
- seg=7'b1111000 on digit 0;
- seg=7'b1111111 on digits 1-3.
REQ-040 Assert rst_n=0 for one cycle mid-scan, with index=2 and value=16'h1234 -> next cycle value=0, an=4'b1110, seg=7'b1000000.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and the 7-segment glyph table.
// Used by the digit entry/encoder stage and the display scanner.
package bcd_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    // Active-low segments, bit order {g,f,e,d,c,b,a}, indexed by BCD code.
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [3:0] AN_RESET  = 4'b1110;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= 4'd9;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decode; codes 10-15 blank.
// Zero latency, no flow control.
module bcd_to_7seg
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (is_bcd(digit)) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/bcd_digit_display.sv
// Four-digit BCD entry register with a multiplexed 7-segment scanner.
// Entry updates next edge; seg/an registered (latency 1); no backpressure.
module bcd_digit_display
    import bcd_pkg::*;
#(
    parameter int SCAN_DIV = 1000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  digit_in,
    input  logic        digit_valid,
    input  logic        clear,
    output logic [15:0] value,
    output logic [2:0]  count,
    output logic        overflow,
    output logic        err,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [2:0]  COUNT_FULL = 3'(NUM_DIGITS);

    logic [15:0] scan_cnt;
    logic [1:0]  index;
    logic [3:0]  cur_digit;
    logic [6:0]  cur_seg;
    logic        blank;

    // Digit entry: clear beats a same-cycle strobe, which is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clear) begin
                value    <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (digit_valid) begin
                if (is_bcd(digit_in)) begin
                    value <= {value[11:0], digit_in};
                    if (count == COUNT_FULL) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + 3'd1;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    // Free-running scan; independent of entry so keypresses never cause flicker.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            index    <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            index    <= index + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    assign cur_digit = value[{index, 2'b00} +: 4];
    assign blank     = ({1'b0, index} >= count) && (index != 2'd0);

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .seg   (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= SEG_ZERO;
            an  <= AN_RESET;
        end else begin
            seg <= blank ? SEG_BLANK : cur_seg;
            an  <= an_select(index);
        end
    end

endmodule
